// File: rtl/el2_dccm_sram_sink.sv
// -----------------------------------------------------------------------------
// el2_dccm_sram_sink
// Responder end of the DCCM SRAM port. Holds the per-bank {ecc,data} storage
// the core accesses and returns read data with one cycle of latency. After
// reset it zero-fills every entry, then goes READY. A one-shot channel can
// corrupt the next read word of a chosen bank, for ECC checking.
//
// Ports
//   clk, rst             clock, asynchronous active-high reset
//   dccm_clken[NB]       per-bank access enable
//   dccm_wren_bank[NB]   per-bank write (only meaningful with clken)
//   dccm_addr_bank       per-bank word index
//   dccm_wr_data_bank    per-bank write data
//   dccm_wr_ecc_bank     per-bank write ECC
//   dccm_bank_dout       per-bank read data (registered, held between reads)
//   dccm_bank_ecc        per-bank read ECC  (registered, held between reads)
//   init_done            high once the zero-fill has finished
//   inj_valid/inj_ready  error-injection handshake
//   inj_bank, inj_bit    target bank and bit index into {ecc,data}
//   inj_double           also flip bit (inj_bit+1) mod W
//   inj_done             one-cycle pulse when the corrupted word is driven
// -----------------------------------------------------------------------------
module el2_dccm_sram_sink #(
  parameter int DCCM_NUM_BANKS  = 4,
  parameter int DCCM_DATA_WIDTH = 32,
  parameter int DCCM_ECC_WIDTH  = 7,
  parameter int DCCM_BITS       = 16,
  parameter int DCCM_BANK_BITS  = 2,
  parameter int INIT_EN         = 1,
  localparam int IDX_W = DCCM_BITS - DCCM_BANK_BITS - 2,
  localparam int DEPTH = 2 ** IDX_W,
  localparam int W     = DCCM_DATA_WIDTH + DCCM_ECC_WIDTH
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic [DCCM_NUM_BANKS-1:0]                      dccm_clken,
  input  logic [DCCM_NUM_BANKS-1:0]                      dccm_wren_bank,
  input  logic [DCCM_NUM_BANKS-1:0][IDX_W-1:0]           dccm_addr_bank,
  input  logic [DCCM_NUM_BANKS-1:0][DCCM_DATA_WIDTH-1:0] dccm_wr_data_bank,
  input  logic [DCCM_NUM_BANKS-1:0][DCCM_ECC_WIDTH-1:0]  dccm_wr_ecc_bank,
  output logic [DCCM_NUM_BANKS-1:0][DCCM_DATA_WIDTH-1:0] dccm_bank_dout,
  output logic [DCCM_NUM_BANKS-1:0][DCCM_ECC_WIDTH-1:0]  dccm_bank_ecc,
  output logic                                           init_done,
  input  logic                                           inj_valid,
  output logic                                           inj_ready,
  input  logic [DCCM_BANK_BITS-1:0]                      inj_bank,
  input  logic [5:0]                                     inj_bit,
  input  logic                                           inj_double,
  output logic                                           inj_done
);

  typedef enum logic {ST_INIT, ST_READY} state_t;

  localparam state_t RESET_STATE = (INIT_EN != 0) ? ST_INIT : ST_READY;

  state_t                                     state_q, state_d;
  logic [IDX_W-1:0]                           cnt_q, cnt_d;
  logic                                       init_done_q, init_done_d;
  logic                                       armed_q, armed_d;
  logic [DCCM_BANK_BITS-1:0]                  inj_bank_q, inj_bank_d;
  logic [5:0]                                 inj_bit_q, inj_bit_d;
  logic                                       inj_double_q, inj_double_d;
  logic                                       inj_done_q, inj_done_d;
  logic [DCCM_NUM_BANKS-1:0][DCCM_DATA_WIDTH-1:0] dout_q, dout_d;
  logic [DCCM_NUM_BANKS-1:0][DCCM_ECC_WIDTH-1:0]  ecc_q, ecc_d;

  logic [W-1:0] rd_word [DCCM_NUM_BANKS];
  logic [W-1:0] word;

  // Flip mask over {ecc,data}. Indices at or beyond W flip nothing; the
  // second bit of a double flip wraps from W back to 0.
  function automatic logic [W-1:0] inj_mask(input logic [5:0] bit_idx, input logic dbl);
    logic [W-1:0] m;
    int           first;
    int           second;
    m      = '0;
    first  = int'(bit_idx);
    second = first + 1;
    if (second == W) second = 0;
    for (int i = 0; i < W; i++) begin
      if ((i == first) || (dbl && (i == second))) m[i] = 1'b1;
    end
    return m;
  endfunction

  // Storage: during INIT every bank is written with zero at cnt; once READY
  // the core owns the write port. Storage itself is never reset.
  for (genvar b = 0; b < DCCM_NUM_BANKS; b++) begin : g_bank
    logic [W-1:0]     mem [DEPTH];
    logic             mem_we;
    logic [IDX_W-1:0] mem_idx;
    logic [W-1:0]     mem_wdata;

    assign mem_we    = (state_q == ST_INIT) ? 1'b1 : (dccm_clken[b] & dccm_wren_bank[b]);
    assign mem_idx   = (state_q == ST_INIT) ? cnt_q : dccm_addr_bank[b];
    assign mem_wdata = (state_q == ST_INIT) ? '0
                                            : {dccm_wr_ecc_bank[b], dccm_wr_data_bank[b]};
    assign rd_word[b] = mem[dccm_addr_bank[b]];

    always_ff @(posedge clk) begin
      if (mem_we) mem[mem_idx] <= mem_wdata;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    init_done_d  = (state_q == ST_READY);
    armed_d      = armed_q;
    inj_bank_d   = inj_bank_q;
    inj_bit_d    = inj_bit_q;
    inj_double_d = inj_double_q;
    inj_done_d   = 1'b0;
    dout_d       = dout_q;
    ecc_d        = ecc_q;
    word         = '0;

    if (state_q == ST_INIT) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == IDX_W'(DEPTH - 1)) state_d = ST_READY;
    end else begin
      // Accept only while disarmed, so a read in the accept cycle sees
      // armed_q low and is returned clean.
      if (inj_valid && !armed_q) begin
        armed_d      = 1'b1;
        inj_bank_d   = inj_bank;
        inj_bit_d    = inj_bit;
        inj_double_d = inj_double;
      end
      for (int b = 0; b < DCCM_NUM_BANKS; b++) begin
        if (dccm_clken[b] && !dccm_wren_bank[b]) begin
          word = rd_word[b];
          if (armed_q && (inj_bank_q == DCCM_BANK_BITS'(b))) begin
            word       = word ^ inj_mask(inj_bit_q, inj_double_q);
            inj_done_d = 1'b1;
            armed_d    = 1'b0;
          end
          dout_d[b] = word[DCCM_DATA_WIDTH-1:0];
          ecc_d[b]  = word[W-1:DCCM_DATA_WIDTH];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= RESET_STATE;
      cnt_q        <= '0;
      init_done_q  <= 1'b0;
      armed_q      <= 1'b0;
      inj_bank_q   <= '0;
      inj_bit_q    <= '0;
      inj_double_q <= 1'b0;
      inj_done_q   <= 1'b0;
      dout_q       <= '0;
      ecc_q        <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      init_done_q  <= init_done_d;
      armed_q      <= armed_d;
      inj_bank_q   <= inj_bank_d;
      inj_bit_q    <= inj_bit_d;
      inj_double_q <= inj_double_d;
      inj_done_q   <= inj_done_d;
      dout_q       <= dout_d;
      ecc_q        <= ecc_d;
    end
  end

  assign dccm_bank_dout = dout_q;
  assign dccm_bank_ecc  = ecc_q;
  assign init_done      = init_done_q;
  assign inj_done       = inj_done_q;
  assign inj_ready      = (state_q == ST_READY) && !armed_q;

endmodule

// File: tb/tb_el2_dccm_sram_sink.sv
module tb_el2_dccm_sram_sink;

  localparam int NB    = 4;
  localparam int DW    = 32;
  localparam int EW    = 7;
  localparam int IDX_W = 12;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [NB-1:0]          dccm_clken = '0;
  logic [NB-1:0]          dccm_wren_bank = '0;
  logic [NB-1:0][IDX_W-1:0] dccm_addr_bank = '0;
  logic [NB-1:0][DW-1:0]  dccm_wr_data_bank = '0;
  logic [NB-1:0][EW-1:0]  dccm_wr_ecc_bank = '0;
  logic [NB-1:0][DW-1:0]  dccm_bank_dout;
  logic [NB-1:0][EW-1:0]  dccm_bank_ecc;
  logic                   init_done;
  logic                   inj_valid = 1'b0;
  logic                   inj_ready;
  logic [1:0]             inj_bank = '0;
  logic [5:0]             inj_bit = '0;
  logic                   inj_double = 1'b0;
  logic                   inj_done;

  int checks = 0;
  int errors = 0;
  int n;

  el2_dccm_sram_sink dut (
    .clk               (clk),
    .rst               (rst),
    .dccm_clken        (dccm_clken),
    .dccm_wren_bank    (dccm_wren_bank),
    .dccm_addr_bank    (dccm_addr_bank),
    .dccm_wr_data_bank (dccm_wr_data_bank),
    .dccm_wr_ecc_bank  (dccm_wr_ecc_bank),
    .dccm_bank_dout    (dccm_bank_dout),
    .dccm_bank_ecc     (dccm_bank_ecc),
    .init_done         (init_done),
    .inj_valid         (inj_valid),
    .inj_ready         (inj_ready),
    .inj_bank          (inj_bank),
    .inj_bit           (inj_bit),
    .inj_double        (inj_double),
    .inj_done          (inj_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Count edges from reset release until init_done rises; the first-init
  // variant also drives core traffic that must be ignored.
  task automatic run_init(input bit with_traffic);
    n = 0;
    while (!init_done && n < 5000) begin
      if (with_traffic && n < 8) begin
        dccm_clken     = '1;
        dccm_wren_bank = '0;
        dccm_addr_bank = '0;
      end else if (with_traffic && n >= 4088 && n < 4096) begin
        dccm_clken        = '1;
        dccm_wren_bank    = '1;
        dccm_addr_bank    = '0;
        dccm_wr_data_bank = {NB{32'h1234_5678}};
        dccm_wr_ecc_bank  = {NB{7'h55}};
      end else begin
        dccm_clken     = '0;
        dccm_wren_bank = '0;
      end
      tick();
      n++;
      if (with_traffic && n == 5) chk("dout_during_init", dccm_bank_dout, 128'h0);
    end
    dccm_clken     = '0;
    dccm_wren_bank = '0;
    chk("init_cycles", n, 4097);
  endtask

  task automatic read_all(input logic [IDX_W-1:0] idx);
    dccm_clken     = '1;
    dccm_wren_bank = '0;
    dccm_addr_bank = {NB{idx}};
    tick();
    dccm_clken = '0;
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_init_done", init_done, 1'b0);
    chk("rst_dout", dccm_bank_dout, 128'h0);
    chk("rst_ecc", dccm_bank_ecc, 28'h0);
    chk("rst_inj_ready", inj_ready, 1'b0);
    chk("rst_inj_done", inj_done, 1'b0);
    tick();
    rst = 1'b0;

    // Zero-init with core traffic that must be ignored
    run_init(1'b1);
    read_all(12'd0);
    chk("rd0_dout", dccm_bank_dout, 128'h0);
    chk("rd0_ecc", dccm_bank_ecc, 28'h0);
    read_all(12'd4095);
    chk("rd4095_dout", dccm_bank_dout, 128'h0);
    chk("rd4095_ecc", dccm_bank_ecc, 28'h0);

    // Write then read bank 1 index 5
    dccm_clken           = 4'b0010;
    dccm_wren_bank       = 4'b0010;
    dccm_addr_bank[1]    = 12'd5;
    dccm_wr_data_bank[1] = 32'hDEAD_BEEF;
    dccm_wr_ecc_bank[1]  = 7'h2A;
    tick();
    chk("wr_no_dout_change", dccm_bank_dout[1], 32'h0);
    dccm_wren_bank = 4'b0000;
    tick();
    dccm_clken = '0;
    chk("rd5_dout", dccm_bank_dout[1], 32'hDEAD_BEEF);
    chk("rd5_ecc", dccm_bank_ecc[1], 7'h2A);
    tick(); tick(); tick();
    chk("hold_dout", dccm_bank_dout[1], 32'hDEAD_BEEF);
    chk("hold_ecc", dccm_bank_ecc[1], 7'h2A);

    // Single-bit injection on bank 1, bit 3
    chk("inj_ready_idle", inj_ready, 1'b1);
    inj_valid = 1'b1; inj_bank = 2'd1; inj_bit = 6'd3; inj_double = 1'b0;
    tick();
    inj_valid = 1'b0;
    chk("inj_ready_armed", inj_ready, 1'b0);
    dccm_clken = 4'b0010; dccm_addr_bank[1] = 12'd5;
    tick();
    dccm_clken = '0;
    chk("inj1_dout", dccm_bank_dout[1], 32'hDEAD_BEE7);
    chk("inj1_ecc", dccm_bank_ecc[1], 7'h2A);
    chk("inj1_done", inj_done, 1'b1);
    tick();
    chk("inj1_done_pulse", inj_done, 1'b0);
    chk("inj1_ready_back", inj_ready, 1'b1);
    dccm_clken = 4'b0010;
    tick();
    dccm_clken = '0;
    chk("reread_dout", dccm_bank_dout[1], 32'hDEAD_BEEF);
    chk("reread_done", inj_done, 1'b0);

    // Double injection at bit 38 wraps to bit 0; a write to bank 1 and a
    // read of bank 0 must not consume it
    inj_valid = 1'b1; inj_bank = 2'd1; inj_bit = 6'd38; inj_double = 1'b1;
    tick();
    inj_valid = 1'b0;
    dccm_clken = 4'b0011; dccm_wren_bank = 4'b0010;
    dccm_addr_bank[0] = 12'd0; dccm_addr_bank[1] = 12'd6;
    dccm_wr_data_bank[1] = 32'h0; dccm_wr_ecc_bank[1] = 7'h0;
    tick();
    dccm_clken = '0; dccm_wren_bank = '0;
    chk("inj2_bank0_clean", dccm_bank_dout[0], 32'h0);
    chk("inj2_wr_no_done", inj_done, 1'b0);
    chk("inj2_still_armed", inj_ready, 1'b0);
    dccm_clken = 4'b0010; dccm_addr_bank[1] = 12'd5;
    tick();
    dccm_clken = '0;
    chk("inj2_dout", dccm_bank_dout[1], 32'hDEAD_BEEE);
    chk("inj2_ecc", dccm_bank_ecc[1], 7'h6A);
    chk("inj2_done", inj_done, 1'b1);

    // Read in the handshake cycle is clean; the following read is corrupted
    inj_valid = 1'b1; inj_bank = 2'd2; inj_bit = 6'd0; inj_double = 1'b0;
    dccm_clken = 4'b0100; dccm_addr_bank[2] = 12'd0;
    tick();
    inj_valid = 1'b0;
    chk("same_cycle_clean", dccm_bank_dout[2], 32'h0);
    chk("same_cycle_no_done", inj_done, 1'b0);
    tick();
    dccm_clken = '0;
    chk("inj3_dout", dccm_bank_dout[2], 32'h1);
    chk("inj3_done", inj_done, 1'b1);

    // Out-of-range bit index: no flip, still consumed
    tick();
    inj_valid = 1'b1; inj_bank = 2'd3; inj_bit = 6'd63; inj_double = 1'b0;
    tick();
    inj_valid = 1'b0;
    dccm_clken = 4'b1000; dccm_addr_bank[3] = 12'd0;
    tick();
    dccm_clken = '0;
    chk("inj4_dout", dccm_bank_dout[3], 32'h0);
    chk("inj4_ecc", dccm_bank_ecc[3], 7'h0);
    chk("inj4_done", inj_done, 1'b1);
    tick();
    chk("inj4_ready_back", inj_ready, 1'b1);

    // Asynchronous reset, then reset again mid-init at cnt=100
    rst = 1'b1;
    #1;
    chk("arst_dout", dccm_bank_dout, 128'h0);
    chk("arst_init_done", init_done, 1'b0);
    chk("arst_inj_ready", inj_ready, 1'b0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 100; i++) tick();
    chk("mid_init_not_done", init_done, 1'b0);
    rst = 1'b1;
    #1;
    chk("mid_rst_init_done", init_done, 1'b0);
    chk("mid_rst_dout", dccm_bank_dout, 128'h0);
    tick();
    rst = 1'b0;
    run_init(1'b0);
    read_all(12'd5);
    chk("post_reinit_dout", dccm_bank_dout, 128'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
